// File: rtl/fastclkdiv_ctl_pkg.sv
// Shared encodings for the fastclkdiv control stage: sequencer states and run modes.
package fastclkdiv_ctl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    typedef enum logic {
        MODE_PERIODIC = 1'b0,
        MODE_ONESHOT  = 1'b1
    } mode_e;

endpackage

// File: rtl/fastclkdiv_ctl_if.sv
// Control/config/status bundle between fastclkdiv_ctl, its host and the attached fastclkdiv.
interface fastclkdiv_ctl_if #(
    parameter int NBITS    = 9,
    parameter int PW_BITS  = 8,
    parameter int CNT_BITS = 16
);
    logic                i_start;
    logic                i_stop;
    logic                i_mode;
    logic [NBITS-1:0]    i_cfg_div;
    logic                i_cfg_div_wr;
    logic [PW_BITS-1:0]  i_cfg_pw;
    logic                i_div_zero;
    logic                o_div_en;
    logic                o_div_load;
    logic [NBITS-1:0]    o_div_load_q;
    logic                o_tick;
    logic                o_pulse;
    logic                o_busy;
    logic                o_cfg_pending;
    logic [CNT_BITS-1:0] o_period_cnt;

    modport master (
        output i_start, i_stop, i_mode, i_cfg_div, i_cfg_div_wr, i_cfg_pw, i_div_zero,
        input  o_div_en, o_div_load, o_div_load_q, o_tick, o_pulse, o_busy,
               o_cfg_pending, o_period_cnt
    );

    modport slave (
        input  i_start, i_stop, i_mode, i_cfg_div, i_cfg_div_wr, i_cfg_pw, i_div_zero,
        output o_div_en, o_div_load, o_div_load_q, o_tick, o_pulse, o_busy,
               o_cfg_pending, o_period_cnt
    );
endinterface

// File: rtl/fastclkdiv.sv
// Loadable down-counter with terminal-count flag; the divider driven by fastclkdiv_ctl.
module fastclkdiv #(
    parameter int NBITS       = 9,
    parameter int NBITS_STAGE = 4
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [NBITS-1:0] i_load_q,
    output logic             o_zero
);
    logic [NBITS-1:0] cnt_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (i_load) begin
            cnt_q <= i_load_q;
        end else if (i_en) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    // Zero detect split at the stage boundary so each half stays a short reduction.
    assign o_zero = (cnt_q[NBITS_STAGE-1:0] == '0) && (cnt_q[NBITS-1:NBITS_STAGE] == '0);
endmodule

// File: rtl/fastclkdiv_ctl_pulse_stretch.sv
// Stretches a one-cycle tick into a registered pulse of programmable width; retriggerable.
module fastclkdiv_ctl_pulse_stretch #(
    parameter int PW_BITS = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tick,
    input  logic [PW_BITS-1:0] width,
    output logic               pulse
);
    logic [PW_BITS-1:0] rem_q;
    logic [PW_BITS-1:0] rem_d;

    always_comb begin
        rem_d = rem_q;
        if (tick) begin
            rem_d = width;
        end else if (rem_q != '0) begin
            rem_d = rem_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            pulse <= 1'b0;
        end else begin
            rem_q <= rem_d;
            pulse <= (rem_d != '0);
        end
    end
endmodule

// File: rtl/fastclkdiv_ctl.sv
// Start/stop sequencer around fastclkdiv with shadowed divisor, tick strobe,
// stretched output pulse and period counter.
module fastclkdiv_ctl
    import fastclkdiv_ctl_pkg::*;
#(
    parameter int               NBITS     = 9,
    parameter int               PW_BITS   = 8,
    parameter int               CNT_BITS  = 16,
    parameter logic [NBITS-1:0] DIV_RESET = '0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    fastclkdiv_ctl_if.slave    bus
);
    state_e              state_q;
    state_e              state_d;
    mode_e               mode_q;
    logic [NBITS-1:0]    active_q;
    logic [NBITS-1:0]    shadow_q;
    logic                pending_q;
    logic [CNT_BITS-1:0] period_cnt_q;
    logic                in_run;
    logic                in_load;
    logic                start_go;
    logic                tick;
    logic                tick_reload;

    assign in_run      = (state_q == RUN);
    assign in_load     = (state_q == LOAD);
    assign start_go    = (state_q == IDLE) && bus.i_start && !bus.i_stop;
    assign tick        = in_run && bus.i_div_zero;
    // A stop coinciding with zero still ticks but must not rearm the divider.
    assign tick_reload = tick && (mode_q == MODE_PERIODIC) && !bus.i_stop;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_go) state_d = LOAD;
            LOAD:    state_d = bus.i_stop ? IDLE : RUN;
            RUN:     if (bus.i_stop || (tick && mode_q == MODE_ONESHOT)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mode_q       <= MODE_PERIODIC;
            active_q     <= DIV_RESET;
            shadow_q     <= DIV_RESET;
            pending_q    <= 1'b0;
            period_cnt_q <= '0;
        end else begin
            if (start_go) begin
                mode_q       <= mode_e'(bus.i_mode);
                period_cnt_q <= '0;
            end else if (tick) begin
                period_cnt_q <= period_cnt_q + CNT_BITS'(1);
            end

            if (tick_reload && pending_q) begin
                active_q  <= shadow_q;
                pending_q <= 1'b0;
            end

            // Later assignment wins: a write on a reload edge stays pending for the next tick.
            if (bus.i_cfg_div_wr) begin
                if (state_q == IDLE) begin
                    active_q  <= bus.i_cfg_div;
                    pending_q <= 1'b0;
                end else begin
                    shadow_q  <= bus.i_cfg_div;
                    pending_q <= 1'b1;
                end
            end
        end
    end

    assign bus.o_div_en      = in_run;
    assign bus.o_div_load    = in_load || tick_reload;
    assign bus.o_div_load_q  = pending_q ? shadow_q : active_q;
    assign bus.o_tick        = tick;
    assign bus.o_busy        = in_load || in_run;
    assign bus.o_cfg_pending = pending_q;
    assign bus.o_period_cnt  = period_cnt_q;

    fastclkdiv_ctl_pulse_stretch #(
        .PW_BITS(PW_BITS)
    ) u_pulse (
        .clk   (i_clk),
        .rst_n (i_rst_n),
        .tick  (tick),
        .width (bus.i_cfg_pw),
        .pulse (bus.o_pulse)
    );
endmodule

// File: tb/tb_fastclkdiv_ctl.sv
// Bench for fastclkdiv_ctl driving a real fastclkdiv: directed scenarios plus random traffic
// checked every cycle against a cycle-schedule model.
module tb_fastclkdiv_ctl;
    logic clk;
    logic rst_n;
    int   checks   = 0;
    int   failures = 0;

    fastclkdiv_ctl_if #(.NBITS(9), .PW_BITS(8), .CNT_BITS(16)) bus ();

    fastclkdiv_ctl #(
        .NBITS(9), .PW_BITS(8), .CNT_BITS(16), .DIV_RESET(9'd0)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    fastclkdiv #(.NBITS(9), .NBITS_STAGE(4)) u_div (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_en     (bus.o_div_en),
        .i_load   (bus.o_div_load),
        .i_load_q (bus.o_div_load_q),
        .o_zero   (bus.i_div_zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    // Model: tracks when ticks are due as absolute cycle numbers.
    longint cyc           = 0;
    longint m_next_tick   = 0;
    longint m_pulse_until = -1;
    bit     m_known   = 0;
    bit     m_busy    = 0;
    bit     m_in_load = 0;
    bit     m_oneshot = 0;
    bit     m_pending = 0;
    int     m_active  = 0;
    int     m_shadow  = 0;
    int     m_cnt     = 0;

    always @(negedge clk) begin
        bit e_run, e_tick, e_load;
        int e_q;
        e_run  = m_busy && !m_in_load;
        e_tick = e_run && (cyc == m_next_tick);
        e_load = m_in_load || (e_tick && !m_oneshot && !bus.i_stop);
        e_q    = m_pending ? m_shadow : m_active;
        if (m_known) begin
            chk("m_div_en",  int'(bus.o_div_en),      int'(e_run));
            chk("m_load",    int'(bus.o_div_load),    int'(e_load));
            chk("m_load_q",  int'(bus.o_div_load_q),  e_q);
            chk("m_tick",    int'(bus.o_tick),        int'(e_tick));
            chk("m_busy",    int'(bus.o_busy),        int'(m_busy));
            chk("m_pending", int'(bus.o_cfg_pending), int'(m_pending));
            chk("m_cnt",     int'(bus.o_period_cnt),  m_cnt);
            chk("m_pulse",   int'(bus.o_pulse),       int'(cyc <= m_pulse_until));
        end
        if (!rst_n) begin
            m_known = 1; m_busy = 0; m_in_load = 0; m_oneshot = 0; m_pending = 0;
            m_active = 0; m_shadow = 0; m_cnt = 0; m_pulse_until = -1;
        end else if (m_known) begin
            if (e_tick) begin
                m_cnt = (m_cnt + 1) % 65536;
                m_pulse_until = cyc + longint'(bus.i_cfg_pw);
            end
            if (!m_busy) begin
                if (bus.i_cfg_div_wr) begin
                    m_active  = int'(bus.i_cfg_div);
                    m_pending = 0;
                end
                if (bus.i_start && !bus.i_stop) begin
                    m_busy = 1; m_in_load = 1; m_oneshot = bus.i_mode; m_cnt = 0;
                end
            end else begin
                if (m_in_load) begin
                    m_next_tick = cyc + longint'(e_q) + 1;
                    m_in_load   = 0;
                    if (bus.i_stop) m_busy = 0;
                end else begin
                    if (e_tick && !bus.i_stop && !m_oneshot) begin
                        m_next_tick = cyc + longint'(e_q) + 1;
                        if (m_pending) begin
                            m_active  = m_shadow;
                            m_pending = 0;
                        end
                    end
                    if (bus.i_stop || (e_tick && m_oneshot)) m_busy = 0;
                end
                if (bus.i_cfg_div_wr) begin
                    m_shadow  = int'(bus.i_cfg_div);
                    m_pending = 1;
                end
            end
        end
        cyc++;
    end

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge; returns at the negedge of the tick cycle.
    task automatic wait_tick(output int n);
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.o_tick) return;
            if (n > 2000) begin
                chk("tick_timeout", n, -1);
                return;
            end
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    task automatic next_tick(output int n);
        int k;
        adv();
        wait_tick(k);
        n = k + 1;
    endtask

    task automatic count_cycles(input int len, output int ticks, output int pulses);
        ticks = 0;
        pulses = 0;
        for (int i = 0; i < len; i++) begin
            @(posedge clk);
            @(negedge clk);
            ticks  += int'(bus.o_tick);
            pulses += int'(bus.o_pulse);
        end
    endtask

    initial begin
        int n, tk, pl;
        rst_n = 1'b0;
        bus.i_start = 0; bus.i_stop = 0; bus.i_mode = 0;
        bus.i_cfg_div = '0; bus.i_cfg_div_wr = 0; bus.i_cfg_pw = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        chk("rst_busy", int'(bus.o_busy), 0);
        chk("rst_cnt", int'(bus.o_period_cnt), 0);
        chk("rst_pulse", int'(bus.o_pulse), 0);

        // Periodic with D = 100
        bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd100;
        adv();
        bus.i_cfg_div_wr = 0; bus.i_start = 1;
        adv();
        bus.i_start = 0;
        wait_tick(n);   chk("t1_first", n, 101);
        next_tick(n);   chk("t1_period2", n, 101);
        next_tick(n);   chk("t1_period3", n, 101);
        adv();
        chk("t1_cnt3", int'(bus.o_period_cnt), 3);

        // Shadow write mid-period
        bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd1;
        adv();
        bus.i_cfg_div_wr = 0;
        chk("t2_pending", int'(bus.o_cfg_pending), 1);
        adv();
        wait_tick(n);
        chk("t2_old_period", n + 3, 101);
        chk("t2_reload_q", int'(bus.o_div_load_q), 1);
        next_tick(n);   chk("t2_new_period", n, 2);
        chk("t2_pending_clr", int'(bus.o_cfg_pending), 0);

        // Write D = 0 exactly on a tick
        adv();
        adv();
        bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd0;
        @(negedge clk);
        chk("t3_on_tick", int'(bus.o_tick), 1);
        chk("t3_old_q", int'(bus.o_div_load_q), 1);
        adv();
        bus.i_cfg_div_wr = 0;
        wait_tick(n);   chk("t3_interval", n + 1, 2);
        chk("t3_new_q", int'(bus.o_div_load_q), 0);
        count_cycles(6, tk, pl);
        chk("t3_every_cycle", tk, 6);

        // One-shot with D = 10
        adv();
        bus.i_stop = 1;
        adv();
        bus.i_stop = 0; bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd10;
        adv();
        bus.i_cfg_div_wr = 0; bus.i_mode = 1; bus.i_start = 1;
        adv();
        bus.i_start = 0; bus.i_mode = 0;
        wait_tick(n);   chk("t4_oneshot", n, 11);
        adv();
        chk("t4_busy", int'(bus.o_busy), 0);
        chk("t4_div_en", int'(bus.o_div_en), 0);
        chk("t4_cnt", int'(bus.o_period_cnt), 1);
        count_cycles(30, tk, pl);
        chk("t4_no_more", tk, 0);

        // Overlapping pulses, then pw = 0
        adv();
        bus.i_cfg_pw = 8'd5; bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd2;
        adv();
        bus.i_cfg_div_wr = 0; bus.i_start = 1;
        adv();
        bus.i_start = 0;
        wait_tick(n);   chk("t5_first", n, 3);
        count_cycles(30, tk, pl);
        chk("t5_pulse_solid", pl, 30);
        chk("t5_ticks", tk, 10);
        adv();
        bus.i_stop = 1;
        adv();
        bus.i_stop = 0; bus.i_cfg_pw = 8'd0;
        repeat (10) adv();
        bus.i_start = 1;
        adv();
        bus.i_start = 0;
        wait_tick(n);
        count_cycles(30, tk, pl);
        chk("t5_pw0", pl, 0);

        // Stop coinciding with zero
        adv();
        wait_tick(n);
        adv();
        adv();
        adv();
        bus.i_stop = 1;
        @(negedge clk);
        chk("t6_stop_tick", int'(bus.o_tick), 1);
        chk("t6_stop_noload", int'(bus.o_div_load), 0);
        adv();
        bus.i_stop = 0;
        chk("t6_stop_idle", int'(bus.o_busy), 0);

        // Reset mid-run with a pending write and an active pulse
        bus.i_cfg_pw = 8'd8; bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd5;
        adv();
        bus.i_cfg_div_wr = 0; bus.i_start = 1;
        adv();
        bus.i_start = 0;
        wait_tick(n);   chk("t6_d5", n, 6);
        adv();
        chk("t6_pulse_on", int'(bus.o_pulse), 1);
        bus.i_cfg_div_wr = 1; bus.i_cfg_div = 9'd7;
        adv();
        bus.i_cfg_div_wr = 0;
        chk("t6_pend_on", int'(bus.o_cfg_pending), 1);
        rst_n = 1'b0;
        adv();
        rst_n = 1'b1;
        chk("t6_rst_busy", int'(bus.o_busy), 0);
        chk("t6_rst_en", int'(bus.o_div_en), 0);
        chk("t6_rst_pend", int'(bus.o_cfg_pending), 0);
        chk("t6_rst_cnt", int'(bus.o_period_cnt), 0);
        chk("t6_rst_pulse", int'(bus.o_pulse), 0);
        chk("t6_rst_q", int'(bus.o_div_load_q), 0);
        chk("t6_rst_tick", int'(bus.o_tick), 0);

        // Start together with stop
        bus.i_start = 1; bus.i_stop = 1;
        adv();
        bus.i_start = 0; bus.i_stop = 0;
        chk("t6_startstop", int'(bus.o_busy), 0);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            bus.i_start      = ($urandom_range(0, 19) == 0);
            bus.i_stop       = ($urandom_range(0, 59) == 0);
            bus.i_mode       = 1'($urandom_range(0, 1));
            bus.i_cfg_div_wr = ($urandom_range(0, 14) == 0);
            bus.i_cfg_div    = 9'($urandom_range(0, 12));
            bus.i_cfg_pw     = 8'($urandom_range(0, 6));
            rst_n            = ($urandom_range(0, 499) != 0);
            adv();
        end
        rst_n = 1'b1;
        bus.i_start = 0; bus.i_stop = 0; bus.i_cfg_div_wr = 0;
        repeat (5) adv();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
